// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 8-bit, 4-register CPU.
// Optional feature macro: HALT_ON_SELF_JUMP_EN (a jump to its own address parks the core in IDLE).
module multicycle_controller #(
    parameter int PC_W        = 8,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            Run,
    input  logic [7:0]      InstrIn,
    output logic [PC_W-1:0] PcOut,
    output logic [1:0]      RegRs,
    output logic [1:0]      RegRt,
    output logic [1:0]      RegWAddr,
    output logic            RegWrite,
    output logic [7:0]      ImmExt,
    output logic            AluSrcImm,
    output logic            MemReq,
    output logic            MemWe,
    input  logic            MemAck,
    output logic            MemErr,
    output logic            Busy
);

    localparam int TMR_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [PC_W-1:0]  PC_ONE   = PC_W'(1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MEM_TIMEOUT - 1);

    localparam logic [1:0] OP_ADD   = 2'd0;
    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_STORE = 2'd2;
    localparam logic [1:0] OP_JUMP  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    function automatic logic [7:0] sext2(input logic [1:0] v);
        return {{6{v[1]}}, v};
    endfunction

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      ir_q, ir_d;
    logic [1:0]      rs_q, rs_d, rt_q, rt_d, waddr_q, waddr_d;
    logic [7:0]      imm_q, imm_d;
    logic            alu_src_q, alu_src_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic            mem_err_q, mem_err_d;
    logic            reg_write_q, reg_write_d;
    logic            busy_q, busy_d;
    logic            halted_q, halted_d;
    logic [TMR_W-1:0] timer_q, timer_d;

    logic [1:0]      op_s;
    logic [PC_W-1:0] jump_off_s;
    logic            self_jump_s;

    assign op_s       = ir_q[7:6];
    // PC_W is assumed wider than the 6-bit jump offset.
    assign jump_off_s = {{(PC_W-6){ir_q[5]}}, ir_q[5:0]};

`ifdef HALT_ON_SELF_JUMP_EN
    assign self_jump_s = (ir_q[5:0] == 6'h3F);
`else
    assign self_jump_s = 1'b0;
`endif

    // Next-state, datapath-register and registered-output decode.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        imm_d    = imm_q;
        waddr_d  = waddr_q;
        mem_err_d = mem_err_q;
        timer_d  = timer_q;
        halted_d = halted_q;

        case (state_q)
            S_IDLE: begin
                // A halted core waits for Run to fall before a new rising Run can start it.
                if (halted_q) begin
                    if (!Run) begin
                        halted_d = 1'b0;
                    end else begin
                        halted_d = 1'b1;
                    end
                end else if (Run) begin
                    state_d   = S_FETCH;
                    mem_err_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                ir_d    = InstrIn;
                rs_d    = InstrIn[5:4];
                rt_d    = InstrIn[3:2];
                imm_d   = sext2(InstrIn[1:0]);
                pc_d    = pc_q + PC_ONE;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (op_s)
                    OP_ADD: begin
                        waddr_d = ir_q[1:0];
                        state_d = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        timer_d = '0;
                        state_d = S_MEM;
                    end
                    OP_JUMP: begin
                        pc_d = pc_q + jump_off_s;
                        if (self_jump_s) begin
                            halted_d = 1'b1;
                            state_d  = S_IDLE;
                        end else if (Run) begin
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
            S_MEM: begin
                if (MemAck) begin
                    timer_d = '0;
                    if (op_s == OP_LOAD) begin
                        waddr_d = ir_q[3:2];
                        state_d = S_WB;
                    end else if (Run) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (timer_q == TMR_LAST) begin
                    // Abort without writeback; MemErr stays set until the next start from IDLE.
                    timer_d   = '0;
                    mem_err_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end
            S_WB: begin
                if (Run) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        reg_write_d = (state_d == S_WB);
        mem_req_d   = (state_d == S_MEM);
        mem_we_d    = (state_d == S_MEM) && (op_s == OP_STORE);
        alu_src_d   = ((state_d == S_EXEC) || (state_d == S_MEM)) &&
                      ((op_s == OP_LOAD) || (op_s == OP_STORE));
        busy_d      = (state_d != S_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            ir_q        <= 8'h00;
            rs_q        <= 2'd0;
            rt_q        <= 2'd0;
            imm_q       <= 8'h00;
            waddr_q     <= 2'd0;
            alu_src_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_err_q   <= 1'b0;
            reg_write_q <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            imm_q       <= imm_d;
            waddr_q     <= waddr_d;
            alu_src_q   <= alu_src_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_err_q   <= mem_err_d;
            reg_write_q <= reg_write_d;
            busy_q      <= busy_d;
            halted_q    <= halted_d;
            timer_q     <= timer_d;
        end
    end

    assign PcOut     = pc_q;
    assign RegRs     = rs_q;
    assign RegRt     = rt_q;
    assign RegWAddr  = waddr_q;
    assign RegWrite  = reg_write_q;
    assign ImmExt    = imm_q;
    assign AluSrcImm = alu_src_q;
    assign MemReq    = mem_req_q;
    assign MemWe     = mem_we_q;
    assign MemErr    = mem_err_q;
    assign Busy      = busy_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: instruction memory model, programmable
// MemAck responder, hand-computed expectations sampled on the falling clock edge.
module tb_multicycle_controller;

    logic       clk;
    logic       rst_n;
    logic       Run;
    logic [7:0] InstrIn;
    logic [7:0] PcOut;
    logic [1:0] RegRs, RegRt, RegWAddr;
    logic       RegWrite;
    logic [7:0] ImmExt;
    logic       AluSrcImm, MemReq, MemWe, MemAck, MemErr, Busy;

    logic [7:0] imem [256];
    assign InstrIn = imem[PcOut];

    int n_checks = 0;
    int n_fail   = 0;

    logic ack_en    = 1'b1;
    int   ack_delay = 1;

    multicycle_controller #(.PC_W(8), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .Run(Run), .InstrIn(InstrIn), .PcOut(PcOut),
        .RegRs(RegRs), .RegRt(RegRt), .RegWAddr(RegWAddr), .RegWrite(RegWrite),
        .ImmExt(ImmExt), .AluSrcImm(AluSrcImm), .MemReq(MemReq), .MemWe(MemWe),
        .MemAck(MemAck), .MemErr(MemErr), .Busy(Busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Data-memory model: single-cycle ack after ack_delay cycles of MemReq.
    initial begin
        int age;
        age    = 0;
        MemAck = 1'b0;
        forever begin
            @(negedge clk);
            if (MemAck) begin
                MemAck = 1'b0;
                age    = 0;
            end else if (MemReq && ack_en) begin
                if (age >= ack_delay) begin
                    MemAck = 1'b1;
                    age    = 0;
                end else begin
                    age = age + 1;
                end
            end else begin
                age = 0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int   n_req, n_st, n_rw, c;
        logic req_prev, seen_idle;
        logic [1:0] last_waddr;
        int   rw_cyc[$];
        logic [1:0] rw_addr[$];
        int   exp_rw_cyc[3]  = '{6, 12, 16};
        logic [1:0] exp_rw_addr[3] = '{2'd1, 2'd2, 2'd3};
        int   fetch_c[4] = '{1, 7, 13, 17};

        for (int i = 0; i < 256; i++) imem[i] = 8'h00;
        imem[0] = 8'h45;   // load r1,[r0+1]
        imem[1] = 8'h49;   // load r2,[r0+1]
        imem[2] = 8'h1B;   // add r3 = r1 + r2
        imem[3] = 8'h8C;   // store r3,[r0+0]

        rst_n = 1'b0;
        Run   = 1'b0;
        tick();
        tick();
        check_eq("rst_pc",      PcOut, 0);
        check_eq("rst_busy",    Busy, 0);
        check_eq("rst_memreq",  MemReq, 0);
        check_eq("rst_memwe",   MemWe, 0);
        check_eq("rst_memerr",  MemErr, 0);
        check_eq("rst_regwr",   RegWrite, 0);
        check_eq("rst_alusrc",  AluSrcImm, 0);
        rst_n = 1'b1;
        tick();

        // Four-instruction program with one-cycle-wait memory.
        n_req = 0; n_st = 0; req_prev = 1'b0;
        Run = 1'b1;
        for (int cc = 1; cc <= 22; cc++) begin
            tick();
            if (cc == 20) Run = 1'b0;
            if (MemReq && !req_prev) begin
                n_req++;
                if (MemWe) n_st++;
            end
            req_prev = MemReq;
            if (RegWrite) begin
                rw_cyc.push_back(cc);
                rw_addr.push_back(RegWAddr);
            end
            for (int k = 0; k < 4; k++)
                if (cc == fetch_c[k]) check_eq("prog_fetch_pc", PcOut, k);
            if (cc == 2)  check_eq("prog_dec_rt", RegRt, 1);
            if (cc == 3)  check_eq("prog_ld_alusrc", AluSrcImm, 1);
            if (cc == 15) check_eq("prog_add_alusrc", AluSrcImm, 0);
        end
        check_eq("prog_nreq", n_req, 3);
        check_eq("prog_nstore", n_st, 1);
        check_eq("prog_nrw", rw_cyc.size(), 3);
        for (int i = 0; i < rw_cyc.size() && i < 3; i++) begin
            check_eq("prog_rw_cyc", rw_cyc[i], exp_rw_cyc[i]);
            check_eq("prog_rw_addr", rw_addr[i], exp_rw_addr[i]);
        end
        check_eq("prog_end_pc", PcOut, 4);
        check_eq("prog_end_busy", Busy, 0);

        // add r0+r1->r3 at PC=4.
        imem[4] = 8'h07;
        Run = 1'b1;
        tick(); check_eq("add_fetch_pc", PcOut, 4);
        tick(); check_eq("add_rs", RegRs, 0); check_eq("add_rt", RegRt, 1);
        tick(); check_eq("add_alusrc", AluSrcImm, 0); check_eq("add_no_wr_early", RegWrite, 0);
        tick(); check_eq("add_regwr", RegWrite, 1); check_eq("add_waddr", RegWAddr, 3);
        Run = 1'b0;
        tick(); check_eq("add_regwr_pulse", RegWrite, 0); check_eq("add_idle", Busy, 0);
        check_eq("add_pc", PcOut, 5);

        // jump 0xFE at PC=5 -> 4.
        imem[5] = 8'hFE;
        Run = 1'b1;
        tick(); check_eq("jmp_fetch_pc", PcOut, 5);
        tick(); check_eq("jmp_immext", ImmExt, 8'hFE);
        tick(); Run = 1'b0;
        tick(); check_eq("jmp_target", PcOut, 4); check_eq("jmp_idle", Busy, 0);

        // Self-jump at PC=4.
        imem[4] = 8'hFF;
        Run = 1'b1;
        tick(); tick(); tick();
`ifdef HALT_ON_SELF_JUMP_EN
        tick(); check_eq("halt_busy", Busy, 0); check_eq("halt_pc", PcOut, 4);
        tick(); check_eq("halt_stays", Busy, 0);
`else
        tick(); check_eq("selfjmp_busy", Busy, 1); check_eq("selfjmp_pc", PcOut, 4);
        tick(); tick(); Run = 1'b0;
        tick(); check_eq("selfjmp_stop", Busy, 0); check_eq("selfjmp_stop_pc", PcOut, 4);
`endif
        Run = 1'b0;
        tick();

        // Backward wrap 4 -> 0xFF, then forward wrap 0xFF -> 0x00.
        imem[4]   = 8'hFA;
        imem[255] = 8'hC0;
        Run = 1'b1;
        tick(); tick(); tick(); Run = 1'b0;
        tick(); check_eq("wrap_back_pc", PcOut, 8'hFF);
        Run = 1'b1;
        tick(); check_eq("wrap_fetch_pc", PcOut, 8'hFF);
        tick(); check_eq("wrap_inc_pc", PcOut, 8'h00);
        tick(); Run = 1'b0;
        tick(); check_eq("wrap_jmp_pc", PcOut, 8'h00);

        // Load with no ack: timeout after 15 MEM cycles.
        ack_en = 1'b0;
        n_rw = 0;
        Run = 1'b1;
        for (int cc = 1; cc <= 20; cc++) begin
            tick();
            if (cc == 3) Run = 1'b0;
            if (RegWrite) n_rw++;
            if (cc == 4)  begin check_eq("to_req_start", MemReq, 1); check_eq("to_we", MemWe, 0); end
            if (cc == 18) begin check_eq("to_req_last", MemReq, 1); check_eq("to_err_early", MemErr, 0); end
            if (cc == 19) begin
                check_eq("to_req_drop", MemReq, 0);
                check_eq("to_err", MemErr, 1);
                check_eq("to_idle", Busy, 0);
            end
        end
        check_eq("to_no_wb", n_rw, 0);
        check_eq("to_err_sticky", MemErr, 1);
        ack_en = 1'b1; ack_delay = 1;
        Run = 1'b1;
        tick(); check_eq("to_err_clear", MemErr, 0); check_eq("to_restart_pc", PcOut, 1);

        // Run dropped during MEM of load at PC=1: completes WB, stops at PC=2.
        seen_idle = 1'b0; n_rw = 0; last_waddr = 2'd0;
        c = 0;
        while (c < 40 && !seen_idle) begin
            tick();
            c++;
            if (MemReq) Run = 1'b0;
            if (RegWrite) begin n_rw++; last_waddr = RegWAddr; end
            if (!Busy) seen_idle = 1'b1;
        end
        check_eq("rd_reached_idle", seen_idle, 1);
        check_eq("rd_nrw", n_rw, 1);
        check_eq("rd_waddr", last_waddr, 2);
        check_eq("rd_pc", PcOut, 2);

        // Zero-wait memory: ack in the first MEM cycle.
        imem[2] = 8'h45;
        ack_delay = 0;
        Run = 1'b1;
        tick(); check_eq("zw_fetch_pc", PcOut, 2);
        tick(); tick(); Run = 1'b0;
        tick(); check_eq("zw_req", MemReq, 1);
        tick(); check_eq("zw_regwr", RegWrite, 1); check_eq("zw_waddr", RegWAddr, 1);
        check_eq("zw_req_drop", MemReq, 0);
        tick(); check_eq("zw_idle", Busy, 0); check_eq("zw_pc", PcOut, 3);

        // Reset while a store waits in MEM.
        imem[3] = 8'h8C;
        ack_en = 1'b0;
        Run = 1'b1;
        tick(); tick(); tick(); Run = 1'b0;
        tick(); check_eq("rm_req", MemReq, 1); check_eq("rm_we", MemWe, 1);
        rst_n = 1'b0;
        #1;
        check_eq("rm_req_clr", MemReq, 0);
        check_eq("rm_we_clr", MemWe, 0);
        check_eq("rm_pc", PcOut, 0);
        check_eq("rm_busy", Busy, 0);
        tick(); rst_n = 1'b1;
        tick(); check_eq("rm_stay_idle", Busy, 0); check_eq("rm_no_wr", RegWrite, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
